// File: rtl/enemy_sprite_engine.sv
// Enemy sprite engine: a small table of enemy slots is hit-tested against the
// current raster position. The winning slot's pixel is looked up in an image
// ROM and then a palette ROM, with a fixed 5-cycle latency from hcount/vcount
// to the colour and hit outputs. A frame counter steps the sprite animation.
module enemy_sprite_engine #(
  parameter int          NUM_ENEMIES       = 4,
  parameter int          WIDTH             = 16,
  parameter int          HEIGHT            = 16,
  parameter int          NUM_FRAMES        = 3,
  parameter int          FRAME_PERIOD      = 30,
  parameter logic [7:0]  TRANSPARENT_INDEX = 8'd0,
  parameter logic [23:0] BG_COLOR          = 24'h9290FF,
  localparam int         IDX_W             = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             frame_start_in,
  input  logic             pos_we_in,
  input  logic [IDX_W-1:0] pos_idx_in,
  input  logic [10:0]      pos_x_in,
  input  logic [9:0]       pos_y_in,
  input  logic             alive_in,
  output logic [7:0]       red_out,
  output logic [7:0]       green_out,
  output logic [7:0]       blue_out,
  output logic             hit_valid_out,
  output logic [IDX_W-1:0] hit_idx_out
);

  localparam int ADDR_W = $clog2(WIDTH * HEIGHT * NUM_FRAMES);
  localparam int FR_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int TICK_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

  // Sprite image content: every pixel whose low address bits equal 5 is
  // transparent, the rest carry a non-zero index that encodes the frame.
  function automatic logic [7:0] img_rom(input logic [ADDR_W-1:0] a);
    logic [9:0] a10;
    a10 = 10'(a);
    if (a10[2:0] == 3'd5) return 8'h00;
    return {a10[9:8] + 2'd1, a10[7:6] ^ a10[5:4], a10[3:0]};
  endfunction

  // Palette content: a fixed colour derived from the index.
  function automatic logic [23:0] pal_rom(input logic [7:0] i);
    return {i, ~i, i ^ 8'hA5};
  endfunction

  logic [10:0]            x_q [NUM_ENEMIES];
  logic [9:0]             y_q [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0] alive_q;
  logic [4:0]             idx_ext;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [FR_W-1:0]        frame_q, frame_d;

  logic                   hit_d;
  logic [IDX_W-1:0]       win_d;
  logic [10:0]            dx_d;
  logic [9:0]             dy_d;
  logic [ADDR_W-1:0]      addr_d;

  logic                   vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q, vld_p5_q;
  logic [IDX_W-1:0]       idx_p1_q, idx_p2_q, idx_p3_q, idx_p4_q, idx_p5_q;
  logic [ADDR_W-1:0]      addr_p1_q;
  logic [7:0]             img_p2_q, img_p3_q;
  logic [23:0]            pal_p4_q, pal_p5_q;

  assign idx_ext = 5'(pos_idx_in);

  // Slot table: cleared on reset, out-of-range slot writes dropped.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      alive_q <= '0;
    end else if (pos_we_in && (idx_ext < 5'(NUM_ENEMIES))) begin
      x_q[pos_idx_in]     <= pos_x_in;
      y_q[pos_idx_in]     <= pos_y_in;
      alive_q[pos_idx_in] <= alive_in;
    end
  end

  // Animation step: tick counts video frames, frame advances on tick wrap.
  always_comb begin
    tick_d  = tick_q;
    frame_d = frame_q;
    if (frame_start_in) begin
      if (tick_q == TICK_W'(FRAME_PERIOD - 1)) begin
        tick_d  = '0;
        frame_d = (frame_q == FR_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // Animation state register.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      tick_q  <= '0;
      frame_q <= '0;
    end else begin
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  // Hit test: walk from highest to lowest slot so the lowest covering index
  // wins; bounds are compared one bit wider so x+WIDTH never wraps.
  always_comb begin
    hit_d = 1'b0;
    win_d = '0;
    dx_d  = '0;
    dy_d  = '0;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (alive_q[i] &&
          ({1'b0, hcount_in} >= {1'b0, x_q[i]}) &&
          ({1'b0, hcount_in} <  ({1'b0, x_q[i]} + 12'(WIDTH))) &&
          ({1'b0, vcount_in} >= {1'b0, y_q[i]}) &&
          ({1'b0, vcount_in} <  ({1'b0, y_q[i]} + 11'(HEIGHT)))) begin
        hit_d = 1'b1;
        win_d = IDX_W'(i);
        dx_d  = hcount_in - x_q[i];
        dy_d  = vcount_in - y_q[i];
      end
    end
    addr_d = ADDR_W'((32'(frame_q) * 32'(HEIGHT) + 32'(dy_d)) * 32'(WIDTH) + 32'(dx_d));
  end

  // Pipeline control: covered flag through p3, covered-and-opaque in p4/p5.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
      vld_p5_q <= 1'b0;
    end else begin
      vld_p1_q <= hit_d;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      vld_p4_q <= vld_p3_q && (img_p3_q != TRANSPARENT_INDEX);
      vld_p5_q <= vld_p4_q;
    end
  end

  // Pipeline data: address, image ROM (2 cycles), palette ROM (2 cycles).
  always_ff @(posedge pixel_clk_in) begin
    // p1: hit test result and image address
    idx_p1_q  <= win_d;
    addr_p1_q <= addr_d;
    // p2/p3: image ROM read and output registers
    idx_p2_q  <= idx_p1_q;
    img_p2_q  <= img_rom(addr_p1_q);
    idx_p3_q  <= idx_p2_q;
    img_p3_q  <= img_p2_q;
    // p4/p5: palette ROM read and output registers
    idx_p4_q  <= idx_p3_q;
    pal_p4_q  <= pal_rom(img_p3_q);
    idx_p5_q  <= idx_p4_q;
    pal_p5_q  <= pal_p4_q;
  end

  assign {red_out, green_out, blue_out} = vld_p5_q ? pal_p5_q : BG_COLOR;
  assign hit_valid_out = vld_p5_q;
  assign hit_idx_out   = vld_p5_q ? idx_p5_q : '0;

endmodule
